// File: rtl/sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with a valid/ready input and an end-of-frame drain.
// Optional saturation and the sticky ovf_o port are enabled by defining SDF_STAGE_SAT_EN.
module sdf_stage #(
  parameter int DATA_W     = 17,
  parameter int LOG2_DELAY = 0,
  parameter int SCALE      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i
`ifdef SDF_STAGE_SAT_EN
  ,
  output logic              ovf_o
`endif
);

  // Handshake: an input sample transfers on a rising edge where valid_i && ready_o.
  // ready_o is low only while draining. valid_o marks one output sample per cycle and
  // cannot be back-pressured.

  localparam int D  = 1 << LOG2_DELAY;
  localparam int CW = LOG2_DELAY + 1;
  localparam logic [CW-1:0] BLK_LAST = CW'(2 * D - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(D - 1);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  state_t                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic                          ready_q;
  logic                          valid_q;
  logic [DATA_W-1:0]             out_r_q;
  logic [DATA_W-1:0]             out_i_q;
  logic [D-1:0][2*DATA_W-1:0]    dl_q;

  logic                          accept;
  logic                          draining;
  logic                          adv;
  logic                          phase_b;
  logic [DATA_W-1:0]             p_r, p_i, x_r, x_i;
  logic [DATA_W:0]               sum_r, sum_i, dif_r, dif_i;
  logic [2*DATA_W-1:0]           out_d;
  logic [2*DATA_W-1:0]           dl_push_d;
  logic                          out_vld_d;

  // Reduce a DATA_W+1 bit sum/difference back to DATA_W bits.
  function automatic logic [DATA_W-1:0] fit(input logic [DATA_W:0] s);
    logic [DATA_W-1:0] v;
    v = s[DATA_W-1:0];
    if (SCALE != 0) v = s[DATA_W:1];
`ifdef SDF_STAGE_SAT_EN
    else if (s[DATA_W] != s[DATA_W-1])
      v = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`endif
    return v;
  endfunction

  assign accept   = valid_i & ready_q;
  assign draining = (state_q == DRAIN);
  assign adv      = accept | draining;
  assign phase_b  = cnt_q[LOG2_DELAY];

  always_comb begin
    p_r       = dl_q[D-1][2*DATA_W-1:DATA_W];
    p_i       = dl_q[D-1][DATA_W-1:0];
    x_r       = draining ? '0 : data_in_r;
    x_i       = draining ? '0 : data_in_i;
    sum_r     = {p_r[DATA_W-1], p_r} + {x_r[DATA_W-1], x_r};
    sum_i     = {p_i[DATA_W-1], p_i} + {x_i[DATA_W-1], x_i};
    dif_r     = {p_r[DATA_W-1], p_r} - {x_r[DATA_W-1], x_r};
    dif_i     = {p_i[DATA_W-1], p_i} - {x_i[DATA_W-1], x_i};
    out_d     = {p_r, p_i};
    dl_push_d = {x_r, x_i};
    out_vld_d = (state_q != FILL);
    if (phase_b) begin
      out_d     = {fit(sum_r), fit(sum_i)};
      dl_push_d = {fit(dif_r), fit(dif_i)};
      out_vld_d = 1'b1;
    end
  end

`ifdef SDF_STAGE_SAT_EN
  logic ovf_q;
  logic clamp_d;

  function automatic logic clips(input logic [1:0] top);
    return (SCALE == 0) && (top[1] != top[0]);
  endfunction

  assign clamp_d = phase_b & (clips(sum_r[DATA_W -: 2]) | clips(sum_i[DATA_W -: 2]) |
                              clips(dif_r[DATA_W -: 2]) | clips(dif_i[DATA_W -: 2]));
  assign ovf_o   = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
`ifdef SDF_STAGE_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= adv & out_vld_d;
      if (adv & out_vld_d) begin
        out_r_q <= out_d[2*DATA_W-1:DATA_W];
        out_i_q <= out_d[DATA_W-1:0];
      end
`ifdef SDF_STAGE_SAT_EN
      if (adv & clamp_d) ovf_q <= 1'b1;
`endif
      unique case (state_q)
        FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == BLK_LAST) state_q <= RUN;
          end
        end
        RUN: begin
          // A sample in the same cycle as flush takes priority; flush only lands on a block boundary.
          if (accept) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (flush_i && cnt_q == '0) begin
            state_q <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (cnt_q == DRN_LAST) begin
            state_q <= FILL;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Delay line is deliberately not reset; stale contents are never marked valid.
  if (D == 1) begin : g_dl_one
    always_ff @(posedge clk) begin
      if (adv) dl_q[0] <= dl_push_d;
    end
  end else begin : g_dl_many
    always_ff @(posedge clk) begin
      if (adv) dl_q <= {dl_q[D-2:0], dl_push_d};
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign data_out_r = out_r_q;
  assign data_out_i = out_i_q;

endmodule

// File: tb/tb_sdf_stage.sv
// Directed bench for sdf_stage: one D=2 instance plus a D=1 pair (SCALE=0 and SCALE=1) sharing inputs.
module tb_sdf_stage;
  localparam int DW = 17;
  localparam int W  = 2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_valid_i, a_flush_i, a_ready_o, a_valid_o;
  logic [DW-1:0] a_in_r, a_in_i, a_out_r, a_out_i;
  logic          b_valid_i, b_flush_i;
  logic [DW-1:0] b_in_r, b_in_i;
  logic          b0_ready_o, b0_valid_o, b1_ready_o, b1_valid_o;
  logic [DW-1:0] b0_out_r, b0_out_i, b1_out_r, b1_out_i;
`ifdef SDF_STAGE_SAT_EN
  logic          a_ovf, b0_ovf, b1_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp1_q[$];

  sdf_stage #(.DATA_W(DW), .LOG2_DELAY(1), .SCALE(0)) u_a (
    .clk(clk), .rst(rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .flush_i(a_flush_i),
    .data_in_r(a_in_r), .data_in_i(a_in_i), .valid_o(a_valid_o),
    .data_out_r(a_out_r), .data_out_i(a_out_i)
`ifdef SDF_STAGE_SAT_EN
    , .ovf_o(a_ovf)
`endif
  );

  sdf_stage #(.DATA_W(DW), .LOG2_DELAY(0), .SCALE(0)) u_b0 (
    .clk(clk), .rst(rst), .valid_i(b_valid_i), .ready_o(b0_ready_o), .flush_i(b_flush_i),
    .data_in_r(b_in_r), .data_in_i(b_in_i), .valid_o(b0_valid_o),
    .data_out_r(b0_out_r), .data_out_i(b0_out_i)
`ifdef SDF_STAGE_SAT_EN
    , .ovf_o(b0_ovf)
`endif
  );

  sdf_stage #(.DATA_W(DW), .LOG2_DELAY(0), .SCALE(1)) u_b1 (
    .clk(clk), .rst(rst), .valid_i(b_valid_i), .ready_o(b1_ready_o), .flush_i(b_flush_i),
    .data_in_r(b_in_r), .data_in_i(b_in_i), .valid_o(b1_valid_o),
    .data_out_r(b1_out_r), .data_out_i(b1_out_i)
`ifdef SDF_STAGE_SAT_EN
    , .ovf_o(b1_ovf)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic reset_all();
    rst = 1'b1;
    a_valid_i = 1'b0; a_flush_i = 1'b0; a_in_r = '0; a_in_i = '0;
    b_valid_i = 1'b0; b_flush_i = 1'b0; b_in_r = '0; b_in_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_a(input logic v, input logic f, input int r, input int im);
    a_valid_i = v; a_flush_i = f; a_in_r = DW'(r); a_in_i = DW'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic f, input int r, input int im);
    b_valid_i = v; b_flush_i = f; b_in_r = DW'(r); b_in_i = DW'(im);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cpx(input int r, input int im);
    logic [DW-1:0] rr, ii;
    rr = DW'(r);
    ii = DW'(im);
    return {rr, ii};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset a ctl: got valid=%b ready=%b want 0/1", a_valid_o, a_ready_o);
    end
    n_checks++;
    if ({a_out_r, a_out_i} !== '0) begin
      n_errors++; $display("FAIL reset a data: got %h want 0", {a_out_r, a_out_i});
    end
    n_checks++;
    if (b0_valid_o !== 1'b0 || b0_ready_o !== 1'b1 || {b0_out_r, b0_out_i} !== '0) begin
      n_errors++; $display("FAIL reset b0: got v=%b r=%b d=%h want 0/1/0", b0_valid_o, b0_ready_o, {b0_out_r, b0_out_i});
    end
    n_checks++;
    if (b1_valid_o !== 1'b0 || b1_ready_o !== 1'b1 || {b1_out_r, b1_out_i} !== '0) begin
      n_errors++; $display("FAIL reset b1: got v=%b r=%b d=%h want 0/1/0", b1_valid_o, b1_ready_o, {b1_out_r, b1_out_i});
    end
`ifdef SDF_STAGE_SAT_EN
    n_checks++;
    if ({a_ovf, b0_ovf, b1_ovf} !== 3'b000) begin
      n_errors++; $display("FAIL reset ovf: got %b want 000", {a_ovf, b0_ovf, b1_ovf});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int sv[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int sf[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int sr[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int ev[8] = '{0, 0, 1, 1, 0, 1, 1, 0};
    int er[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp_q.push_back(cpx(4, 0)); exp_q.push_back(cpx(6, 0));
    exp_q.push_back(cpx(-2, 0)); exp_q.push_back(cpx(-2, 0));
    for (int k = 0; k < 8; k++) begin
      drive_a(1'(sv[k]), 1'(sf[k]), sr[k], 0);
      n_checks++;
      if (a_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL basic valid_o row %0d: got %b want %0d", k, a_valid_o, ev[k]);
      end
      n_checks++;
      if (a_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL basic ready_o row %0d: got %b want %0d", k, a_ready_o, er[k]);
      end
      if (a_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({a_out_r, a_out_i} !== want) begin
          n_errors++; $display("FAIL basic data row %0d: got %h want %h", k, {a_out_r, a_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL basic count: got %0d outputs missing want 0", exp_q.size());
    end
  endtask

  task automatic test_imag();
    int sv[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int sf[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int sr[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    int si[8] = '{10, -20, 5, 7, 0, 0, 0, 0};
    int ev[8] = '{0, 0, 1, 1, 0, 1, 1, 0};
    int er[8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp_q.push_back(cpx(4, 15)); exp_q.push_back(cpx(6, -13));
    exp_q.push_back(cpx(-2, 5)); exp_q.push_back(cpx(-2, -27));
    for (int k = 0; k < 8; k++) begin
      drive_a(1'(sv[k]), 1'(sf[k]), sr[k], si[k]);
      n_checks++;
      if (a_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL imag valid_o row %0d: got %b want %0d", k, a_valid_o, ev[k]);
      end
      n_checks++;
      if (a_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL imag ready_o row %0d: got %b want %0d", k, a_ready_o, er[k]);
      end
      if (a_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({a_out_r, a_out_i} !== want) begin
          n_errors++; $display("FAIL imag data row %0d: got %h want %h", k, {a_out_r, a_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL imag count: got %0d outputs missing want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int sv[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    int sf[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int sr[12] = '{1, 0, 2, 0, 3, 0, 4, 0, 0, 0, 0, 0};
    int ev[12] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0};
    int er[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp_q.push_back(cpx(4, 0)); exp_q.push_back(cpx(6, 0));
    exp_q.push_back(cpx(-2, 0)); exp_q.push_back(cpx(-2, 0));
    for (int k = 0; k < 12; k++) begin
      drive_a(1'(sv[k]), 1'(sf[k]), sr[k], 0);
      n_checks++;
      if (a_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL stall valid_o row %0d: got %b want %0d", k, a_valid_o, ev[k]);
      end
      n_checks++;
      if (a_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL stall ready_o row %0d: got %b want %0d", k, a_ready_o, er[k]);
      end
      if (a_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({a_out_r, a_out_i} !== want) begin
          n_errors++; $display("FAIL stall data row %0d: got %h want %h", k, {a_out_r, a_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL stall count: got %0d outputs missing want 0", exp_q.size());
    end
  endtask

  task automatic test_illegal_flush();
    int sv[18] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
    int sf[18] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    int sr[18] = '{0, 1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 0, 10, 11, 12, 0, 0, 0};
    int ev[18] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    int er[18] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    int ex[12] = '{4, 6, -2, -2, 12, 14, -2, -2, 20, 22, -2, -2};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(cpx(ex[k], 0));
    for (int k = 0; k < 18; k++) begin
      drive_a(1'(sv[k]), 1'(sf[k]), sr[k], 0);
      n_checks++;
      if (a_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL illegal_flush valid_o row %0d: got %b want %0d", k, a_valid_o, ev[k]);
      end
      n_checks++;
      if (a_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL illegal_flush ready_o row %0d: got %b want %0d", k, a_ready_o, er[k]);
      end
      if (a_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({a_out_r, a_out_i} !== want) begin
          n_errors++; $display("FAIL illegal_flush data row %0d: got %h want %h", k, {a_out_r, a_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL illegal_flush count: got %0d outputs missing want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_block();
    int srst[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    int sv[12]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int sf[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int sr[12]   = '{1, 2, 3, 9, 1, 2, 3, 4, 0, 0, 0, 0};
    int ev[12]   = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0};
    int er[12]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp_q.push_back(cpx(4, 0));
    exp_q.push_back(cpx(4, 0)); exp_q.push_back(cpx(6, 0));
    exp_q.push_back(cpx(-2, 0)); exp_q.push_back(cpx(-2, 0));
    for (int k = 0; k < 12; k++) begin
      rst = 1'(srst[k]);
      drive_a(1'(sv[k]), 1'(sf[k]), sr[k], 0);
      n_checks++;
      if (a_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL reset_mid valid_o row %0d: got %b want %0d", k, a_valid_o, ev[k]);
      end
      n_checks++;
      if (a_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL reset_mid ready_o row %0d: got %b want %0d", k, a_ready_o, er[k]);
      end
      if (srst[k] != 0) begin
        n_checks++;
        if ({a_out_r, a_out_i} !== '0) begin
          n_errors++; $display("FAIL reset_mid cleared data: got %h want 0", {a_out_r, a_out_i});
        end
      end
      if (a_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({a_out_r, a_out_i} !== want) begin
          n_errors++; $display("FAIL reset_mid data row %0d: got %h want %h", k, {a_out_r, a_out_i}, want);
        end
      end
    end
    rst = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL reset_mid count: got %0d outputs missing want 0", exp_q.size());
    end
  endtask

  // Shared B-pair check loop body is written out per test; tables differ per scenario.
  task automatic test_back_to_back();
    int sv[7] = '{1, 1, 1, 1, 0, 0, 0};
    int sf[7] = '{0, 0, 0, 0, 1, 0, 0};
    int sr[7] = '{5, 3, 1, 1, 0, 0, 0};
    int ev[7] = '{0, 1, 1, 1, 0, 1, 0};
    int er[7] = '{1, 1, 1, 1, 0, 1, 1};
    int e0[4] = '{8, 2, 2, 0};
    int e1[4] = '{4, 1, 1, 0};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp1_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(cpx(e0[k], 0));
      exp1_q.push_back(cpx(e1[k], 0));
    end
    for (int k = 0; k < 7; k++) begin
      drive_b(1'(sv[k]), 1'(sf[k]), sr[k], 0);
      n_checks++;
      if (b0_valid_o !== 1'(ev[k]) || b1_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL b2b valid_o row %0d: got %b/%b want %0d", k, b0_valid_o, b1_valid_o, ev[k]);
      end
      n_checks++;
      if (b0_ready_o !== 1'(er[k]) || b1_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL b2b ready_o row %0d: got %b/%b want %0d", k, b0_ready_o, b1_ready_o, er[k]);
      end
      if (b0_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({b0_out_r, b0_out_i} !== want) begin
          n_errors++; $display("FAIL b2b data scale0 row %0d: got %h want %h", k, {b0_out_r, b0_out_i}, want);
        end
      end
      if (b1_valid_o === 1'b1 && exp1_q.size() != 0) begin
        want = exp1_q.pop_front();
        n_checks++;
        if ({b1_out_r, b1_out_i} !== want) begin
          n_errors++; $display("FAIL b2b data scale1 row %0d: got %h want %h", k, {b1_out_r, b1_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_errors++; $display("FAIL b2b count: got %0d/%0d outputs missing want 0", exp_q.size(), exp1_q.size());
    end
  endtask

  task automatic test_scale();
    int sv[5] = '{1, 1, 0, 0, 0};
    int sf[5] = '{0, 0, 1, 0, 0};
    int sr[5] = '{1, 4, 0, 0, 0};
    int si[5] = '{-7, 2, 0, 0, 0};
    int ev[5] = '{0, 1, 0, 1, 0};
    int er[5] = '{1, 1, 0, 1, 1};
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp1_q.delete();
    exp_q.push_back(cpx(5, -5));  exp_q.push_back(cpx(-3, -9));
    exp1_q.push_back(cpx(2, -3)); exp1_q.push_back(cpx(-2, -5));
    for (int k = 0; k < 5; k++) begin
      drive_b(1'(sv[k]), 1'(sf[k]), sr[k], si[k]);
      n_checks++;
      if (b0_valid_o !== 1'(ev[k]) || b1_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL scale valid_o row %0d: got %b/%b want %0d", k, b0_valid_o, b1_valid_o, ev[k]);
      end
      n_checks++;
      if (b0_ready_o !== 1'(er[k]) || b1_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL scale ready_o row %0d: got %b/%b want %0d", k, b0_ready_o, b1_ready_o, er[k]);
      end
      if (b0_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({b0_out_r, b0_out_i} !== want) begin
          n_errors++; $display("FAIL scale data scale0 row %0d: got %h want %h", k, {b0_out_r, b0_out_i}, want);
        end
      end
      if (b1_valid_o === 1'b1 && exp1_q.size() != 0) begin
        want = exp1_q.pop_front();
        n_checks++;
        if ({b1_out_r, b1_out_i} !== want) begin
          n_errors++; $display("FAIL scale data scale1 row %0d: got %h want %h", k, {b1_out_r, b1_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_errors++; $display("FAIL scale count: got %0d/%0d outputs missing want 0", exp_q.size(), exp1_q.size());
    end
  endtask

  task automatic test_overflow();
    int sv[5] = '{1, 1, 0, 0, 0};
    int sf[5] = '{0, 0, 1, 0, 0};
    int sr[5] = '{65535, 1, 0, 0, 0};
    int si[5] = '{-65536, -1, 0, 0, 0};
    int ev[5] = '{0, 1, 0, 1, 0};
    int er[5] = '{1, 1, 0, 1, 1};
`ifdef SDF_STAGE_SAT_EN
    int eo[5] = '{0, 1, 1, 1, 1};
`endif
    logic [W-1:0] want;
    reset_all();
    exp_q.delete();
    exp1_q.delete();
`ifdef SDF_STAGE_SAT_EN
    exp_q.push_back(cpx(65535, -65536));
`else
    exp_q.push_back(cpx(-65536, 65535));
`endif
    exp_q.push_back(cpx(65534, -65535));
    exp1_q.push_back(cpx(32768, -32769));
    exp1_q.push_back(cpx(32767, -32768));
    for (int k = 0; k < 5; k++) begin
      drive_b(1'(sv[k]), 1'(sf[k]), sr[k], si[k]);
      n_checks++;
      if (b0_valid_o !== 1'(ev[k]) || b1_valid_o !== 1'(ev[k])) begin
        n_errors++; $display("FAIL ovf valid_o row %0d: got %b/%b want %0d", k, b0_valid_o, b1_valid_o, ev[k]);
      end
      n_checks++;
      if (b0_ready_o !== 1'(er[k]) || b1_ready_o !== 1'(er[k])) begin
        n_errors++; $display("FAIL ovf ready_o row %0d: got %b/%b want %0d", k, b0_ready_o, b1_ready_o, er[k]);
      end
`ifdef SDF_STAGE_SAT_EN
      n_checks++;
      if (b0_ovf !== 1'(eo[k]) || b1_ovf !== 1'b0) begin
        n_errors++; $display("FAIL ovf flag row %0d: got %b/%b want %0d/0", k, b0_ovf, b1_ovf, eo[k]);
      end
`endif
      if (b0_valid_o === 1'b1 && exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if ({b0_out_r, b0_out_i} !== want) begin
          n_errors++; $display("FAIL ovf data scale0 row %0d: got %h want %h", k, {b0_out_r, b0_out_i}, want);
        end
      end
      if (b1_valid_o === 1'b1 && exp1_q.size() != 0) begin
        want = exp1_q.pop_front();
        n_checks++;
        if ({b1_out_r, b1_out_i} !== want) begin
          n_errors++; $display("FAIL ovf data scale1 row %0d: got %h want %h", k, {b1_out_r, b1_out_i}, want);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_errors++; $display("FAIL ovf count: got %0d/%0d outputs missing want 0", exp_q.size(), exp1_q.size());
    end
`ifdef SDF_STAGE_SAT_EN
    reset_all();
    n_checks++;
    if (b0_ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf cleared by rst: got %b want 0", b0_ovf);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    a_valid_i = 1'b0; a_flush_i = 1'b0; a_in_r = '0; a_in_i = '0;
    b_valid_i = 1'b0; b_flush_i = 1'b0; b_in_r = '0; b_in_i = '0;
    test_reset();
    test_basic();
    test_imag();
    test_stall();
    test_illegal_flush();
    test_reset_mid_block();
    test_back_to_back();
    test_scale();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdf_stage.md
# sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the pipelined FFT datapath. One instance of any stage: the feedback delay depth is set by parameter. The block adds a valid/ready handshake and an end-of-frame drain so the last block's difference outputs can be flushed without padding input. Instances chain stage-to-stage: delay 16, 8, 4, 2, 1 for the 32-point FFT. Twiddle multiplication stays outside this block.

## Interface
- `DATA_W`, 17: two's-complement width of each real/imag component, in and out.
- `LOG2_DELAY`, 0: feedback depth `D = 2**LOG2_DELAY`, legal range 0..6. Block length is `2D`.
- `SCALE`, 0: 1 = butterfly outputs arithmetic-shifted right by 1 (truncate); 0 = no scaling.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `valid_i`  in  1  input sample present.
- `ready_o`  out  1  stage accepts a sample this cycle; a sample is accepted when `valid_i & ready_o`.
- `flush_i`  in  1  request drain of the stored differences.
- `data_in_r` / `data_in_i`  in  DATA_W each  input sample.
- `valid_o`  out  1  output sample valid; no backpressure.
- `data_out_r` / `data_out_i`  out  DATA_W each  output sample.
- `ovf_o`  out  1  sticky overflow flag. Exists only with `SDF_STAGE_SAT_EN`.

## Operation
- Counter `cnt`: LOG2_DELAY+1 bits. Advances once per accepted sample, or once per drain cycle. Wraps from 2D-1 to 0.
- Delay line: D-entry FIFO-ordered shift register of complex samples. It is not reset, and its contents are masked by `valid_o`.
- Phase A, `cnt < D`:
  - pop the oldest entry `p` and push the input;
  - output = `p`, which is the difference from the previous block.
- Phase B, `cnt >= D`:
  - `p` = x[cnt-D];
  - output = `p + x`;
  - push `p - x`.
- Arithmetic: sum/difference are computed at DATA_W+1 bits.
  - SCALE=1: take bits [DATA_W:1].
  - SCALE=0: take the low DATA_W bits, with wrap or saturate per Configuration.
  - Real and imag are treated independently.
- States:
  - **FILL**: no complete block stored. Phase-A outputs are not valid.
    - Goes to RUN when `cnt` wraps to 0.
  - **RUN**: every accepted sample produces a valid output.
    - On `flush_i & !valid_i & cnt==0`, go to DRAIN.
  - **DRAIN**: `ready_o`=0. Each cycle runs phase A with zero input and emits one valid difference.
    - After D cycles, go to FILL with `cnt`=0.
- `valid_i` and `flush_i` in the same cycle: the sample is accepted and the flush is ignored.
- `flush_i` is ignored in FILL, and in RUN when `cnt != 0`.
- Reset mid-block or mid-drain: the partial block is discarded. The next accepted sample is block index 0 in FILL.

## Timing
- Reset values:
  - `valid_o`=0, `data_out_r`=0, `data_out_i`=0, `ovf_o`=0;
  - `ready_o`=1, state FILL, `cnt`=0.
- All outputs are registered. The result for a sample accepted on edge k appears after edge k, i.e. 1-cycle register latency.
- Pipeline latency: D accepted samples + 1 cycle. The sum for index j appears with the acceptance of index j+D.
- `ready_o` is low only in DRAIN. It goes low the cycle after the accepted flush and high the cycle after the final drain output.
- Gaps in `valid_i` stall the stage: no state change and `valid_o`=0 on those cycles.
- LOG2_DELAY=0: D=1, so phase alternates every sample.

## Configuration
- `SDF_STAGE_SAT_EN` defined:
  - with SCALE=0, overflowed sums/differences clamp to +(2^(DATA_W-1)-1) or -2^(DATA_W-1);
  - `ovf_o` sets on any clamp and clears only on `rst`.
- Undefined: results wrap (low DATA_W bits), and the `ovf_o` port is absent.
- SCALE=1 never overflows; `ovf_o` stays 0.

## Test plan
- **D=2, SCALE=0:** real inputs 1,2,3,4, imag 0, contiguous valid, then flush.
  - Outputs in order: 4, 6, -2, -2, all imag 0.
  - `valid_o` high for exactly 4 cycles; `ready_o` low for 2 cycles.
- **D=1, two back-to-back blocks:** (5,3) then (1,1).
  - Outputs: 8, 2, 2, then 0 after flush.
  - No `valid_o` during the first phase-A sample.
- **Stall:** the first case with one idle cycle inserted between every sample.
  - Same 4 values; `valid_o` gaps track the input gaps.
- **Overflow, DATA_W=17, D=1:** inputs 65535 + 1.
  - Macro defined: sum output 65535, `ovf_o`=1.
  - Macro undefined: -65536.
  - SCALE=1: 32768, `ovf_o`=0.
- **Illegal flush:** `flush_i` at `cnt`=1, and `flush_i` with `valid_i` in the same cycle. Both ignored: no DRAIN, `ready_o` stays 1.
- **Reset mid-block:** `rst` after 3 of 4 samples (D=2), then feed 1,2,3,4.
  - Output identical to the first case; no stale values appear.
